nand_tester: RTL and testbench

Self-checking exerciser for a 2-input gate under test, nominally the NAND. It drives the gate's A/B inputs through all four input vectors and waits a settle interval on each. It then samples the gate output through a 2-flop synchronizer, compares it against a programmable truth table, and reports a per-vector error mask plus pass/done status. It sits on the board side of the gate: it drives the gate's inputs and receives its output, so the lab can check the gate automatically.

---
 rtl/nand_tester.sv | 127 ++++++++++++
 tb/tb_nand_tester.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/nand_tester.sv
// Exercises a 2-input gate through all four input vectors and checks its synchronized
// output against a programmable truth table. Reports a per-vector error mask and pass/done.
`timescale 1ns/1ps
module nand_tester #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  TRUTH         = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_o,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [1:0] vec_idx
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         vec_q, vec_d;
    logic [3:0]         mask_q, mask_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               s1_q, s2_q;

    // Two-flop synchronizer for the asynchronous gate output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= gate_o;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; registered outputs are computed one edge ahead of their state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                mask_d[vec_q] = (s2_q != TRUTH[vec_q]);
                if (vec_q == 2'd3) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = ~|mask_d;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gate_a   = vec_q[1];
    assign gate_b   = vec_q[0];
    assign vec_idx  = vec_q;
    assign err_mask = mask_q;
    assign pass     = pass_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_nand_tester.sv
// Directed bench for nand_tester: swaps gate models behind gate_o and checks masks, timing, reset.
`timescale 1ns/1ps
module tb_nand_tester;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       gate_o;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_mask;
    logic [1:0] vec_idx;

    // 0: ideal NAND, 1: AND, 2: stuck at 1, 3: stuck at 0
    int unsigned mode;
    int          errors;
    int          checks;

    nand_tester #(
        .SETTLE_CYCLES(4),
        .TRUTH        (4'b0111)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .gate_o   (gate_o),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_mask (err_mask),
        .vec_idx  (vec_idx)
    );

    always #5 clk = ~clk;

    assign gate_o = (mode == 0) ? ~(gate_a & gate_b) :
                    (mode == 1) ?  (gate_a & gate_b) :
                    (mode == 2) ? 1'b1 : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({gate_a, gate_b, busy, done, pass, err_mask, vec_idx});
    endfunction

    // One full run from IDLE; poke injects start pulses mid-run and during FINISH
    task automatic run(input string tag, input logic [3:0] exp_mask, input logic exp_pass,
                       input bit poke);
        logic [7:0] seq;
        int         dcyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".clr"}, 32'({busy, pass, err_mask}), 32'({1'b1, 1'b0, 4'b0000}));
        seq  = 8'({gate_a, gate_b});
        dcyc = 0;
        for (int i = 1; i <= 40; i++) begin
            start = poke && (i == 4 || i == 11);
            tick();
            start = 1'b0;
            if (i == 5 || i == 10 || i == 15) seq = {seq[5:0], gate_a, gate_b};
            if (done) begin
                dcyc = i;
                break;
            end
        end
        chk({tag, ".done_cyc"}, 32'(dcyc), 32'd20);
        chk({tag, ".seq"}, 32'(seq), 32'h1B);
        chk({tag, ".mask"}, 32'(err_mask), 32'(exp_mask));
        chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, ".busy_fin"}, 32'(busy), 32'd0);
        start = poke;
        tick();
        start = 1'b0;
        chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk({tag, ".idle_after"}, 32'({busy, done}), 32'd0);
        chk({tag, ".held"}, 32'({pass, err_mask}), 32'({exp_pass, exp_mask}));
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 0;
        errors = 0;
        checks = 0;

        #1;
        chk("reset_outs", all_outs(), 32'd0);
        #20;
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_start", all_outs(), 32'd0);

        mode = 0;
        run("nand", 4'b0000, 1'b1, 1'b0);
        mode = 1;
        run("and", 4'b1111, 1'b0, 1'b0);
        mode = 2;
        run("stuck1", 4'b1000, 1'b0, 1'b0);
        mode = 3;
        run("stuck0_poke", 4'b0111, 1'b0, 1'b1);

        // Reset in the middle of vector 2, asserted mid-cycle
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30 && vec_idx != 2'd2; i++) tick();
        chk("rst.reached_v2", 32'(vec_idx), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst.async", all_outs(), 32'd0);
        tick();
        tick();
        chk("rst.held", all_outs(), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst.stay_idle", all_outs(), 32'd0);
        run("nand_after_rst", 4'b0000, 1'b1, 1'b0);

        // Back-to-back: failing run, then a clean run that must clear mask/pass at start
        mode = 2;
        run("b2b_stuck1", 4'b1000, 1'b0, 1'b0);
        mode = 0;
        run("b2b_nand", 4'b0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
